// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier / serial transmitter slice:
// controller state encoding and serial line levels.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        TX   = 2'd2
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : seq_mult_pkg

// File: rtl/mult_tx_shifter.sv
// Frame serializer: on load, sends start bit, 2*WIDTH data bits LSB first and a
// stop bit, each held for BAUD_DIV clocks; tx_done marks the final stop-bit cycle.
module mult_tx_shifter
    import seq_mult_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int BAUD_DIV = 4
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               load,
    input  logic [2*WIDTH-1:0] data,
    output logic               tx,
    output logic               tx_done
);

    localparam int FRAME_BITS = 2 * WIDTH + 2;
    localparam int BCW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int FCW        = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] frame_q;
    logic [BCW-1:0]        baud_q;
    logic [FCW-1:0]        bit_q;
    logic                  active_q;
    logic                  bit_end;
    logic                  frame_end;

    assign bit_end   = active_q && (baud_q == BCW'(BAUD_DIV - 1));
    assign frame_end = bit_end && (bit_q == FCW'(FRAME_BITS - 1));

    // Frame resets to all ones so the line reads idle the moment reset asserts.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            frame_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            frame_q  <= {STOP_BIT, data, START_BIT};
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (bit_end) begin
                baud_q  <= '0;
                frame_q <= {IDLE_LVL, frame_q[FRAME_BITS-1:1]};
                if (frame_end) begin
                    active_q <= 1'b0;
                    bit_q    <= '0;
                end else begin
                    bit_q <= bit_q + FCW'(1);
                end
            end else begin
                baud_q <= baud_q + BCW'(1);
            end
        end
    end

    assign tx      = frame_q[0];
    assign tx_done = frame_end;

endmodule : mult_tx_shifter

// File: rtl/seq_mult_tx.sv
// Shift-add multiplier (WIDTH iterations) followed by UART-style transmission of
// the product. Optional signed multiply is built when SEQ_MULT_SIGNED_EN is defined.
module seq_mult_tx
    import seq_mult_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int BAUD_DIV = 4
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               tx
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH:0]     ext_upper;
    logic [WIDTH:0]     ext_mcand;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_iter;
    logic               accept;
    logic               finish;
    logic               tx_done;
`ifdef SEQ_MULT_SIGNED_EN
    logic               smode_q;
`endif

    // Bit 0 of the running sum is always shifted out by the next iteration, so
    // only bits above it are stored; the final value is taken from acc_next.
    logic [2*WIDTH-1:1] acc_q;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign accept    = (state_q == IDLE) && start;
    assign finish    = (state_q == MULT) && last_iter;

    // One add/subtract step: WIDTH+1 bits so the carry (or sign) feeds the shift.
    always_comb begin
        ext_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        ext_mcand = {1'b0, mcand_q};
`ifdef SEQ_MULT_SIGNED_EN
        ext_upper[WIDTH] = smode_q & acc_q[2*WIDTH-1];
        ext_mcand[WIDTH] = smode_q & mcand_q[WIDTH-1];
`endif
        sum = ext_upper;
        if (mplier_q[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
            // The multiplier MSB carries negative weight in two's complement.
            if (smode_q && last_iter) sum = ext_upper - ext_mcand;
            else                      sum = ext_upper + ext_mcand;
`else
            sum = ext_upper + ext_mcand;
`endif
        end
        acc_next = {sum, acc_q[WIDTH-1:1]};
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = MULT;
            MULT:    if (last_iter) state_d = TX;
            TX:      if (tx_done)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            smode_q   <= 1'b0;
`endif
        end else begin
            done_q <= finish;
            if (accept) begin
                mcand_q  <= multiplicand;
                mplier_q <= multiplier;
                acc_q    <= '0;
                cnt_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                smode_q  <= signed_mode;
`endif
            end else if (state_q == MULT) begin
                acc_q    <= acc_next[2*WIDTH-1:1];
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
            end
            if (finish) product_q <= acc_next;
        end
    end

    mult_tx_shifter #(
        .WIDTH    (WIDTH),
        .BAUD_DIV (BAUD_DIV)
    ) u_shifter (
        .CLK     (CLK),
        .rst     (rst),
        .load    (finish),
        .data    (acc_next),
        .tx      (tx),
        .tx_done (tx_done)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule : seq_mult_tx

// File: tb/tb_seq_mult_tx.sv
// Directed bench for seq_mult_tx: a WIDTH=4/BAUD_DIV=4 instance checked cycle by
// cycle (busy, done, product, tx) and a WIDTH=8/BAUD_DIV=1 instance.
module tb_seq_mult_tx;

    logic       CLK = 1'b0;
    logic       rst;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       sm4;
    logic       busy4;
    logic       done4;
    logic [7:0] prod4;
    logic       tx4;
    logic [7:0] held4;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;
    logic        tx8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    seq_mult_tx #(.WIDTH(4), .BAUD_DIV(4)) dut4 (
        .CLK          (CLK),
        .rst          (rst),
        .start        (start4),
        .multiplier   (a4),
        .multiplicand (b4),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode  (sm4),
`endif
        .busy         (busy4),
        .done         (done4),
        .product      (prod4),
        .tx           (tx4)
    );

    seq_mult_tx #(.WIDTH(8), .BAUD_DIV(1)) dut8 (
        .CLK          (CLK),
        .rst          (rst),
        .start        (start8),
        .multiplier   (a8),
        .multiplicand (b8),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode  (1'b0),
`endif
        .busy         (busy8),
        .done         (done8),
        .product      (prod8),
        .tx           (tx8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. The start strobe is taken at the next rising edge
    // (edge k); sample j is taken at the falling edge after edge k+j.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic smode,
                          input logic [7:0] exp, input bit keep, input int p1,
                          input int p2, input string name);
        logic [9:0] frame;
        logic       exp_tx;
        frame  = {1'b1, exp, 1'b0};
        a4     = a;
        b4     = b;
        sm4    = smode;
        start4 = 1'b1;
        @(negedge CLK);
        if (!keep) start4 = 1'b0;
        for (int j = 0; j <= 44; j++) begin
            exp_tx = 1'b1;
            if (j >= 4 && j < 44) exp_tx = frame[(j - 4) / 4];
            check($sformatf("%s busy j=%0d", name, j), {31'd0, busy4}, (j < 44) ? 32'd1 : 32'd0);
            check($sformatf("%s done j=%0d", name, j), {31'd0, done4}, (j == 4) ? 32'd1 : 32'd0);
            check($sformatf("%s product j=%0d", name, j), {24'd0, prod4},
                  {24'd0, (j >= 4) ? exp : held4});
            check($sformatf("%s tx j=%0d", name, j), {31'd0, tx4}, {31'd0, exp_tx});
            if (j < 44) begin
                if (j == p1 || j == p2) start4 = 1'b1;
                else if (!keep)         start4 = 1'b0;
                @(negedge CLK);
            end
        end
        held4 = exp;
    endtask

    initial begin
        logic [17:0] frame8;
        logic        exp_tx8;

        rst    = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        sm4    = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        held4  = '0;

        @(negedge CLK);
        check("reset busy",    {31'd0, busy4}, 32'd0);
        check("reset done",    {31'd0, done4}, 32'd0);
        check("reset product", {24'd0, prod4}, 32'd0);
        check("reset tx",      {31'd0, tx4},   32'd1);
        check("reset tx8",     {31'd0, tx8},   32'd1);
        rst = 1'b1;

        run_op(4'b0111, 4'b1110, 1'b0, 8'h62, 1'b0, -1, -1, "7x14");
        run_op(4'b1111, 4'b1111, 1'b0, 8'hE1, 1'b0, -1, -1, "15x15");
        run_op(4'b0000, 4'b1010, 1'b0, 8'h00, 1'b0, -1, -1, "0x10");
        run_op(4'b0101, 4'b0110, 1'b0, 8'h1E, 1'b0, 1, 20, "ignored_starts");
        run_op(4'b0010, 4'b0011, 1'b0, 8'h06, 1'b1, -1, -1, "held_start_a");
        run_op(4'b1001, 4'b1001, 1'b0, 8'h51, 1'b0, -1, -1, "held_start_b");
`ifdef SEQ_MULT_SIGNED_EN
        run_op(4'b1110, 4'b0111, 1'b1, 8'hF2, 1'b0, -1, -1, "signed_-2x7");
        run_op(4'b1000, 4'b1000, 1'b1, 8'h40, 1'b0, -1, -1, "signed_-8x-8");
        run_op(4'b1110, 4'b0111, 1'b0, 8'h62, 1'b0, -1, -1, "unsigned_14x7");
`endif

        // Reset in the middle of a 0x62 frame, during data bit 0 (line low).
        a4     = 4'b0111;
        b4     = 4'b1110;
        sm4    = 1'b0;
        start4 = 1'b1;
        @(negedge CLK);
        start4 = 1'b0;
        repeat (8) @(negedge CLK);
        check("midtx tx before reset", {31'd0, tx4}, 32'd0);
        #1 rst = 1'b0;
        #1;
        check("midtx reset tx",      {31'd0, tx4},   32'd1);
        check("midtx reset busy",    {31'd0, busy4}, 32'd0);
        check("midtx reset product", {24'd0, prod4}, 32'd0);
        check("midtx reset done",    {31'd0, done4}, 32'd0);
        @(negedge CLK);
        rst   = 1'b1;
        held4 = '0;

        run_op(4'b0011, 4'b0101, 1'b0, 8'h0F, 1'b0, -1, -1, "3x5_after_reset");

        // Wide instance: one bit per clock, 18-bit frame.
        frame8 = {1'b1, 16'hFE01, 1'b0};
        a8     = 8'hFF;
        b8     = 8'hFF;
        start8 = 1'b1;
        @(negedge CLK);
        start8 = 1'b0;
        for (int j = 0; j <= 26; j++) begin
            exp_tx8 = 1'b1;
            if (j >= 8 && j < 26) exp_tx8 = frame8[j - 8];
            check($sformatf("w8 busy j=%0d", j), {31'd0, busy8}, (j < 26) ? 32'd1 : 32'd0);
            check($sformatf("w8 done j=%0d", j), {31'd0, done8}, (j == 8) ? 32'd1 : 32'd0);
            check($sformatf("w8 product j=%0d", j), {16'd0, prod8},
                  (j >= 8) ? 32'h0000_FE01 : 32'd0);
            check($sformatf("w8 tx j=%0d", j), {31'd0, tx8}, {31'd0, exp_tx8});
            if (j < 26) @(negedge CLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_mult_tx
